// File: rtl/sbox_subst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : sbox_subst_seq
//  Purpose  : Sequential DES S-box substitution stage. Captures the 48-bit
//             E(R) xor K word and reduces it through S1..S8 into a 32-bit
//             word that is then held for the downstream straight_pbox.
//             Default build evaluates one S-box per cycle. Defining
//             SBOX_DUAL_EN evaluates two S-boxes per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module sbox_subst_seq (
    input  logic        CLK,
    input  logic        RST,
    input  logic [0:47] DIN,
    input  logic        DIN_VALID,
    output logic        DIN_READY,
    output logic [0:31] DOUT,
    output logic        DOUT_VALID,
    input  logic        DOUT_READY,
    output logic        BUSY
);

    // FIPS 46-3 tables, row-major (row 0 col 0 in the top nibble).
    localparam logic [255:0] c_SBOX1 = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    localparam logic [255:0] c_SBOX2 = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    localparam logic [255:0] c_SBOX3 = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    localparam logic [255:0] c_SBOX4 = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    localparam logic [255:0] c_SBOX5 = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    localparam logic [255:0] c_SBOX6 = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    localparam logic [255:0] c_SBOX7 = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    localparam logic [255:0] c_SBOX8 = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

`ifdef SBOX_DUAL_EN
    localparam int c_IDX_W = 2;
`else
    localparam int c_IDX_W = 3;
`endif
    localparam logic [c_IDX_W-1:0] c_IDX_ONE = {{(c_IDX_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Chunk bit 5 is DES bit c[0]; row = {c[0], c[5]}, column = c[1:4].
    function automatic logic [3:0] f_sbox(input logic [2:0] box, input logic [5:0] chunk);
        logic [255:0] tbl;
        logic [5:0]   idx;
        logic [7:0]   pos;
        case (box)
            3'd0:    tbl = c_SBOX1;
            3'd1:    tbl = c_SBOX2;
            3'd2:    tbl = c_SBOX3;
            3'd3:    tbl = c_SBOX4;
            3'd4:    tbl = c_SBOX5;
            3'd5:    tbl = c_SBOX6;
            3'd6:    tbl = c_SBOX7;
            default: tbl = c_SBOX8;
        endcase
        idx = {chunk[5], chunk[0], chunk[4:1]};
        pos = 8'd252 - {idx, 2'b00};
        return tbl[pos +: 4];
    endfunction

    state_t               r_state;
    logic [0:47]          r_din;
    logic [c_IDX_W-1:0]   r_idx;
    logic [0:31]          r_dout;
    logic                 r_dout_valid;
    logic                 r_din_ready;
    logic                 r_busy;

    logic [5:0]           w_din_base;
    logic [4:0]           w_dout_base;
    logic [5:0]           w_chunk0;
    logic [3:0]           w_nib0;
    logic                 w_last;
`ifdef SBOX_DUAL_EN
    logic [5:0]           w_chunk1;
    logic [3:0]           w_nib1;
`endif

    // Select the chunk(s) addressed by the index counter and look them up.
    always_comb begin
`ifdef SBOX_DUAL_EN
        w_din_base  = 6'(r_idx) * 6'd12;
        w_dout_base = 5'(r_idx) * 5'd8;
        w_chunk0    = r_din[w_din_base +: 6];
        w_chunk1    = r_din[(w_din_base + 6'd6) +: 6];
        w_nib0      = f_sbox({r_idx, 1'b0}, w_chunk0);
        w_nib1      = f_sbox({r_idx, 1'b1}, w_chunk1);
        w_last      = (r_idx == 2'd3);
`else
        w_din_base  = 6'(r_idx) * 6'd6;
        w_dout_base = 5'(r_idx) * 5'd4;
        w_chunk0    = r_din[w_din_base +: 6];
        w_nib0      = f_sbox(r_idx, w_chunk0);
        w_last      = (r_idx == 3'd7);
`endif
    end

    // Control FSM with registered handshake outputs and the S-box writes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_din        <= '0;
            r_idx        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_din_ready  <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (DIN_VALID && r_din_ready) begin
                        r_din       <= DIN;
                        r_idx       <= '0;
                        r_dout      <= '0;
                        r_din_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_SUB;
                    end
                end
                S_SUB: begin
                    r_dout[w_dout_base +: 4] <= w_nib0;
`ifdef SBOX_DUAL_EN
                    r_dout[(w_dout_base + 5'd4) +: 4] <= w_nib1;
`endif
                    // Counter wraps to zero on the final write.
                    r_idx <= r_idx + c_IDX_ONE;
                    if (w_last) begin
                        r_busy       <= 1'b0;
                        r_dout_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    // DOUT stays untouched here until the next capture.
                    if (DOUT_READY) begin
                        r_dout_valid <= 1'b0;
                        r_din_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_dout_valid <= 1'b0;
                    r_din_ready  <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign DIN_READY  = r_din_ready;
    assign DOUT       = r_dout;
    assign DOUT_VALID = r_dout_valid;
    assign BUSY       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sbox_subst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sbox_subst_seq
//  Purpose  : Self-checking bench for sbox_subst_seq (either build of
//             SBOX_DUAL_EN). Known-answer vectors, backpressure, async
//             abort and back-to-back throughput.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sbox_subst_seq;

`ifdef SBOX_DUAL_EN
    localparam int c_LAT = 4;
    localparam int c_II  = 6;
`else
    localparam int c_LAT = 8;
    localparam int c_II  = 10;
`endif

    logic        CLK;
    logic        RST;
    logic [0:47] DIN;
    logic        DIN_VALID;
    logic        DIN_READY;
    logic [0:31] DOUT;
    logic        DOUT_VALID;
    logic        DOUT_READY;
    logic        BUSY;

    sbox_subst_seq u_dut (
        .CLK        (CLK),
        .RST        (RST),
        .DIN        (DIN),
        .DIN_VALID  (DIN_VALID),
        .DIN_READY  (DIN_READY),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID),
        .DOUT_READY (DOUT_READY),
        .BUSY       (BUSY)
    );

    typedef struct {
        logic [47:0] din;
        logic [31:0] dout;
    } vec_t;

    vec_t        r_vecs [5];
    logic [31:0] r_sb [$];
    int          r_n_cmp;
    int          r_n_bad;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        r_n_cmp++;
        if (act !== exp) begin
            r_n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Offer one word and wait (bounded) for it to be taken.
    task automatic accept(input logic [47:0] din, input logic [31:0] exp, input string tag);
        bit acc;
        acc       = 1'b0;
        DIN       = din;
        DIN_VALID = 1'b1;
        for (int i = 0; i < 40 && !acc; i++) begin
            acc = DIN_READY;
            tick();
        end
        DIN_VALID = 1'b0;
        chk({tag, "_accept"}, acc, 1);
        chk({tag, "_busy"}, BUSY, 1);
        chk({tag, "_rdy_low"}, DIN_READY, 0);
        r_sb.push_back(exp);
    endtask

    // Wait (bounded) for DOUT_VALID, check latency and data from scoreboard.
    task automatic wait_result(input string tag);
        int          lat;
        logic [31:0] exp;
        lat = 0;
        while (!DOUT_VALID && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, c_LAT);
        chk({tag, "_sb_depth"}, r_sb.size(), 1);
        if (r_sb.size() > 0) begin
            exp = r_sb.pop_front();
            chk({tag, "_dout"}, DOUT, exp);
        end
        if (DOUT_READY) begin
            tick();
            chk({tag, "_pulse"}, DOUT_VALID, 0);
        end
    endtask

    initial begin
        bit          acc;
        bit          prev_v;
        int          bad;
        int          nacc;
        int          nval;
        int          acc_cyc [2];
        logic [47:0] b2b_din [2];
        logic [31:0] b2b_exp [2];

        r_vecs[0] = '{48'h000000000000, 32'hEFA72C4D};
        r_vecs[1] = '{48'hFFFFFFFFFFFF, 32'hD9CE3DCB};
        r_vecs[2] = '{48'h6117BA866527, 32'h5C82B597};
        r_vecs[3] = '{48'h861861861861, 32'hFD13B462};  // every chunk row 3, col 0
        r_vecs[4] = '{48'h082082082082, 32'h410DC1B2};  // every chunk row 0, col 1

        r_n_cmp    = 0;
        r_n_bad    = 0;
        RST        = 1'b0;
        DIN        = '0;
        DIN_VALID  = 1'b0;
        DOUT_READY = 1'b1;

        // Reset state, observed before any clock edge.
        #1 RST = 1'b1;
        #1;
        chk("rst_dout", DOUT, 0);
        chk("rst_valid", DOUT_VALID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_din_ready", DIN_READY, 1);
        tick();
        tick();
        RST = 1'b0;
        tick();

        // Known-answer vectors.
        for (int v = 0; v < 5; v++) begin
            accept(r_vecs[v].din, r_vecs[v].dout, $sformatf("vec%0d", v));
            wait_result($sformatf("vec%0d", v));
        end

        // Backpressure: hold DONE for 20 cycles with new data pending.
        DOUT_READY = 1'b0;
        accept(48'h6117BA866527, 32'h5C82B597, "bp");
        wait_result("bp");
        DIN       = 48'hFFFFFFFFFFFF;
        DIN_VALID = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (DOUT !== 32'h5C82B597 || DIN_READY !== 1'b0 || DOUT_VALID !== 1'b1 || BUSY !== 1'b0)
                bad++;
        end
        chk("bp_hold_violations", bad, 0);
        chk("bp_hold_dout", DOUT, 32'h5C82B597);
        DOUT_READY = 1'b1;
        tick();
        chk("bp_valid_fall", DOUT_VALID, 0);
        chk("bp_not_captured", BUSY, 0);
        chk("bp_idle_ready", DIN_READY, 1);
        chk("bp_dout_kept", DOUT, 32'h5C82B597);
        tick();
        DIN_VALID = 1'b0;
        chk("bp_captured", BUSY, 1);
        chk("bp_dout_cleared", DOUT, 0);
        r_sb.push_back(32'hD9CE3DCB);
        wait_result("bp_next");

        // Asynchronous abort in the 4th SUB cycle.
        accept(48'hFFFFFFFFFFFF, 32'hD9CE3DCB, "abort");
        tick();
        tick();
        tick();
        chk("abort_pre_busy", BUSY, 1);
        #2 RST = 1'b1;
        #1;
        chk("abort_dout", DOUT, 0);
        chk("abort_valid", DOUT_VALID, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_din_ready", DIN_READY, 1);
        r_sb.delete();  // aborted word produces no output
        tick();
        #2 RST = 1'b0;
        nval = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (DOUT_VALID) nval++;
        end
        chk("abort_no_valid", nval, 0);
        accept(48'h000000000000, 32'hEFA72C4D, "post_abort");
        wait_result("post_abort");

        // Back-to-back with DIN_VALID held high.
        b2b_din[0] = 48'h000000000000;  b2b_exp[0] = 32'hEFA72C4D;
        b2b_din[1] = 48'h6117BA866527;  b2b_exp[1] = 32'h5C82B597;
        nacc       = 0;
        nval       = 0;
        prev_v     = 1'b0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        DIN        = b2b_din[0];
        DIN_VALID  = 1'b1;
        DOUT_READY = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            acc = DIN_VALID && DIN_READY;
            tick();
            if (acc && nacc < 2) begin
                acc_cyc[nacc] = cyc;
                r_sb.push_back(b2b_exp[nacc]);
                nacc++;
                if (nacc < 2) DIN = b2b_din[nacc];
                else          DIN_VALID = 1'b0;
            end
            if (DOUT_VALID) begin
                chk("b2b_pulse", prev_v, 0);
                chk("b2b_sb_depth", r_sb.size(), 1);
                if (r_sb.size() > 0) chk("b2b_dout", DOUT, r_sb.pop_front());
                nval++;
            end
            prev_v = DOUT_VALID;
        end
        chk("b2b_accepts", nacc, 2);
        chk("b2b_spacing", acc_cyc[1] - acc_cyc[0], c_II);
        chk("b2b_results", nval, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", r_n_cmp, r_n_bad);
        $finish;
    end

endmodule
`default_nettype wire
